// File: rtl/wb_sram_burst_if.sv
// wb_sram_burst_if: Wishbone B3 bus bundle between a master and
// the burst-capable SRAM slave.
interface wb_sram_burst_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   modport master (
      output cyc, stb, we, addr, sel, wdata, cti, bte,
      input  rdata, ack, err
   );

   modport slave (
      input  cyc, stb, we, addr, sel, wdata, cti, bte,
      output rdata, ack, err
   );
endinterface

// File: rtl/wb_sram_burst.sv
// wb_sram_burst: Wishbone B3 SRAM slave with wait states, address
// window error response and registered-feedback incrementing bursts.
module wb_sram_burst #(
   parameter int          ADDR_W      = 13,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter bit          BURST_EN    = 1'b1
) (
   input logic            clk_i,
   input logic            rst_i,
   wb_sram_burst_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE, S_WAIT, S_BURST, S_DONE
   } state_t;

   state_t            state;
   logic [31:0]       mem [2**ADDR_W];
   logic [ADDR_W-1:0] baddr;
   logic [ADDR_W-1:0] nxt;
   logic [ADDR_W-1:0] word;
   logic [ADDR_W-1:0] wmask;
   logic [2:0]        wcnt;
   logic              ack_q;
   logic              err_q;
   logic              req;
   logic              hit;
   logic              beat;
   logic              go_burst;
   logic              unused_addr;

   assign req      = bus.cyc & bus.stb;
   assign word     = bus.addr[ADDR_W+1:2];
   assign hit      = bus.addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
   assign go_burst = BURST_EN && bus.cti == 3'b010;
   // a beat completes only while the master still strobes
   assign beat     = ack_q & req;
   assign bus.ack  = beat;
   assign bus.err  = err_q & req;
   assign unused_addr = ^bus.addr[1:0];

   always_comb begin
      unique case (bus.bte)
         2'b01:   wmask = ADDR_W'(3);
         2'b10:   wmask = ADDR_W'(7);
         2'b11:   wmask = ADDR_W'(15);
         default: wmask = '1;
      endcase
      nxt = (baddr & ~wmask) | ((baddr + ADDR_W'(1)) & wmask);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && beat && bus.we) begin
         for (int b = 0; b < 4; b++)
            if (bus.sel[b])
               mem[baddr][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         baddr     <= '0;
         wcnt      <= '0;
         bus.rdata <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req) begin
                  baddr <= word;
                  if (!hit) begin
                     err_q <= 1'b1;
                     state <= S_DONE;
                  end else if (WAIT_STATES > 0) begin
                     wcnt  <= 3'(WAIT_STATES);
                     state <= S_WAIT;
                  end else begin
                     ack_q     <= 1'b1;
                     bus.rdata <= mem[word];
                     state     <= go_burst ? S_BURST : S_DONE;
                  end
               end
            end
            S_WAIT: begin
               if (!bus.cyc) begin
                  wcnt  <= '0;
                  state <= S_IDLE;
               end else if (wcnt == 3'd1) begin
                  wcnt      <= '0;
                  ack_q     <= 1'b1;
                  bus.rdata <= mem[baddr];
                  state     <= go_burst ? S_BURST : S_DONE;
               end else begin
                  wcnt <= wcnt - 3'd1;
               end
            end
            S_BURST: begin
               if (!bus.cyc) begin
                  ack_q <= 1'b0;
                  state <= S_IDLE;
               end else if (beat) begin
                  if (bus.cti != 3'b010) begin
                     ack_q <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     // prefetch so the next beat's data rides with its ack
                     baddr     <= nxt;
                     bus.rdata <= mem[nxt];
                  end
               end
            end
            S_DONE: begin
               ack_q <= 1'b0;
               err_q <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wb_sram_burst.sv
// tb_wb_sram_burst: scoreboard bench for the Wishbone burst SRAM,
// one zero-wait-state instance and one with three wait states.
module tb_wb_sram_burst;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tgt = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we_r = 1'b0;
   logic [31:0] addr = '0;
   logic [3:0]  sel = '0;
   logic [31:0] wdata = '0;
   logic [2:0]  cti = '0;
   logic [1:0]  bte_r = '0;
   logic        ack_w;
   logic        err_w;
   logic [31:0] rdata_w;

   logic [31:0] exp_q [$];
   logic [31:0] rd_q [$];
   int          ac_q [$];
   logic [31:0] wbuf [16];
   int          n_cmp = 0;
   int          n_bad = 0;

   wb_sram_burst_if b0 ();
   wb_sram_burst_if b3 ();

   assign b0.cyc   = cyc & ~tgt;
   assign b3.cyc   = cyc & tgt;
   assign b0.stb   = stb;
   assign b3.stb   = stb;
   assign b0.we    = we_r;
   assign b3.we    = we_r;
   assign b0.addr  = addr;
   assign b3.addr  = addr;
   assign b0.sel   = sel;
   assign b3.sel   = sel;
   assign b0.wdata = wdata;
   assign b3.wdata = wdata;
   assign b0.cti   = cti;
   assign b3.cti   = cti;
   assign b0.bte   = bte_r;
   assign b3.bte   = bte_r;
   assign ack_w    = tgt ? b3.ack : b0.ack;
   assign err_w    = tgt ? b3.err : b0.err;
   assign rdata_w  = tgt ? b3.rdata : b0.rdata;

   wb_sram_burst #(
      .ADDR_W(8), .WAIT_STATES(0), .BASE_ADDR(BASE), .BURST_EN(1'b1)
   ) dut0 (
      .clk_i(clk), .rst_i(rst), .bus(b0)
   );

   wb_sram_burst #(
      .ADDR_W(8), .WAIT_STATES(3), .BASE_ADDR(BASE), .BURST_EN(1'b1)
   ) dut3 (
      .clk_i(clk), .rst_i(rst), .bus(b3)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] wa(input int w);
      return BASE | 32'(w * 4);
   endfunction

   // one classic cycle; strobe stays up one extra cycle to expose re-acks
   task automatic classic(input bit t, input bit w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output int lat,
                          output bit ak, output bit er, output bit extra);
      int n = 0;
      @(posedge clk); #1;
      tgt = t; cyc = 1; stb = 1; we_r = w; addr = a;
      sel = s; wdata = d; cti = 3'b000; bte_r = 2'b00;
      ak = 0; er = 0; rd = '0; lat = -1; extra = 0;
      while (n < 30 && !ak && !er) begin
         @(negedge clk); n++;
         ak = ack_w; er = err_w;
         if (ak || er) begin
            lat = n - 1;
            rd = rdata_w;
         end
      end
      @(negedge clk);
      extra = ack_w | err_w;
      cyc = 0; stb = 0;
   endtask

   task automatic burst(input bit w, input int w0, input logic [1:0] bt,
                        input int n, input int st_at, input int st_len);
      int beat = 0;
      int k = 0;
      int st = 0;
      rd_q.delete(); ac_q.delete();
      @(posedge clk); #1;
      tgt = 0; cyc = 1; stb = 1; we_r = w; addr = wa(w0);
      sel = 4'hF; bte_r = bt; wdata = wbuf[0];
      cti = (n == 1) ? 3'b111 : 3'b010;
      while (beat < n && k < 200) begin
         @(negedge clk); k++;
         if (stb && ack_w) begin
            rd_q.push_back(rdata_w);
            ac_q.push_back(k);
            beat++;
         end
         @(posedge clk); #1;
         if (beat == st_at && st < st_len) begin
            stb = 0; st++;
         end else if (beat < n) begin
            stb = 1; wdata = wbuf[beat];
            cti = (beat == n - 1) ? 3'b111 : 3'b010;
         end
      end
      cyc = 0; stb = 0;
   endtask

   task automatic test_reset();
      rst = 1; tgt = 0; cyc = 1; stb = 1; addr = wa(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (b0.ack !== 1'b0) begin
         n_bad++; $display("FAIL reset_ack got=%b exp=0", b0.ack);
      end
      n_cmp++;
      if (b0.err !== 1'b0) begin
         n_bad++; $display("FAIL reset_err got=%b exp=0", b0.err);
      end
      n_cmp++;
      if (b0.rdata !== 32'h0) begin
         n_bad++; $display("FAIL reset_rdata0 got=%h exp=0", b0.rdata);
      end
      n_cmp++;
      if (b3.rdata !== 32'h0) begin
         n_bad++; $display("FAIL reset_rdata3 got=%h exp=0", b3.rdata);
      end
      cyc = 0; stb = 0;
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic test_classic();
      logic [31:0] rd; int lat; bit ak, er, ex;
      classic(0, 1, wa(4), 4'hF, 32'hDEADBEEF, rd, lat, ak, er, ex);
      n_cmp++;
      if (!ak || lat !== 1) begin
         n_bad++; $display("FAIL wr_ack ack=%b lat=%0d exp ack=1 lat=1", ak, lat);
      end
      exp_q.push_back(32'hDEADBEEF);
      classic(0, 0, wa(4), 4'hF, 32'h0, rd, lat, ak, er, ex);
      n_cmp++;
      if (!ak || lat !== 1) begin
         n_bad++; $display("FAIL rd_ack ack=%b lat=%0d exp ack=1 lat=1", ak, lat);
      end
      n_cmp++;
      if (rd !== exp_q.pop_front()) begin
         n_bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd);
      end
      n_cmp++;
      if (ex !== 1'b0) begin
         n_bad++; $display("FAIL rd_single_pulse extra=%b exp=0", ex);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd; int lat; bit ak, er, ex;
      classic(0, 1, wa(8), 4'hF, 32'h11223344, rd, lat, ak, er, ex);
      classic(0, 1, wa(8), 4'b0010, 32'h0000AA00, rd, lat, ak, er, ex);
      exp_q.push_back(32'h1122AA44);
      classic(0, 0, wa(8), 4'hF, 32'h0, rd, lat, ak, er, ex);
      n_cmp++;
      if (rd !== exp_q.pop_front()) begin
         n_bad++; $display("FAIL byte_lane got=%h exp=1122aa44", rd);
      end
      classic(0, 1, wa(8), 4'b0000, 32'hFFFFFFFF, rd, lat, ak, er, ex);
      n_cmp++;
      if (!ak) begin
         n_bad++; $display("FAIL sel0_ack got=%b exp=1", ak);
      end
      exp_q.push_back(32'h1122AA44);
      classic(0, 0, wa(8), 4'hF, 32'h0, rd, lat, ak, er, ex);
      n_cmp++;
      if (rd !== exp_q.pop_front()) begin
         n_bad++; $display("FAIL sel0_nochange got=%h exp=1122aa44", rd);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; int lat; bit ak, er, ex;
      classic(1, 1, wa(4), 4'hF, 32'hCAFE0003, rd, lat, ak, er, ex);
      n_cmp++;
      if (!ak || lat !== 4) begin
         n_bad++; $display("FAIL ws_wr_lat ack=%b lat=%0d exp=4", ak, lat);
      end
      exp_q.push_back(32'hCAFE0003);
      classic(1, 0, wa(4), 4'hF, 32'h0, rd, lat, ak, er, ex);
      n_cmp++;
      if (!ak || lat !== 4) begin
         n_bad++; $display("FAIL ws_rd_lat ack=%b lat=%0d exp=4", ak, lat);
      end
      n_cmp++;
      if (rd !== exp_q.pop_front()) begin
         n_bad++; $display("FAIL ws_rd_data got=%h exp=cafe0003", rd);
      end
      n_cmp++;
      if (ex !== 1'b0) begin
         n_bad++; $display("FAIL ws_no_reack extra=%b exp=0", ex);
      end
      tgt = 0;
   endtask

   task automatic test_decode_error();
      logic [31:0] rd; int lat; bit ak, er, ex;
      classic(0, 1, 32'h2000_0010, 4'hF, 32'h0BAD0BAD, rd, lat, ak, er, ex);
      n_cmp++;
      if (er !== 1'b1 || lat !== 1) begin
         n_bad++; $display("FAIL miss_err err=%b lat=%0d exp err=1 lat=1", er, lat);
      end
      n_cmp++;
      if (ak !== 1'b0) begin
         n_bad++; $display("FAIL miss_ack got=%b exp=0", ak);
      end
      n_cmp++;
      if (ex !== 1'b0) begin
         n_bad++; $display("FAIL miss_err_pulse extra=%b exp=0", ex);
      end
      exp_q.push_back(32'hDEADBEEF);
      classic(0, 0, wa(4), 4'hF, 32'h0, rd, lat, ak, er, ex);
      n_cmp++;
      if (rd !== exp_q.pop_front()) begin
         n_bad++; $display("FAIL miss_ram_kept got=%h exp=deadbeef", rd);
      end
   endtask

   task automatic test_burst();
      logic [31:0] e;
      int span;
      int g [3];
      for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
      burst(1, 0, 2'b00, 16, 99, 0);
      span = (ac_q.size() == 16) ? ac_q[15] - ac_q[0] : -1;
      n_cmp++;
      if (span !== 15) begin
         n_bad++; $display("FAIL lin_wr_acks beats=%0d span=%0d exp 16/15", ac_q.size(), span);
      end

      exp_q.push_back(32'd6); exp_q.push_back(32'd7);
      exp_q.push_back(32'd4); exp_q.push_back(32'd5);
      burst(0, 6, 2'b01, 4, 2, 2);
      n_cmp++;
      if (rd_q.size() !== 4) begin
         n_bad++; $display("FAIL wrap4_beats got=%0d exp=4", rd_q.size());
      end
      foreach (rd_q[i]) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_q[i] !== e) begin
            n_bad++; $display("FAIL wrap4_data[%0d] got=%h exp=%h", i, rd_q[i], e);
         end
      end
      exp_q.delete();
      for (int i = 0; i < 3; i++)
         g[i] = (ac_q.size() == 4) ? ac_q[i+1] - ac_q[i] : -1;
      n_cmp++;
      if (g[0] !== 1 || g[1] !== 3 || g[2] !== 1) begin
         n_bad++; $display("FAIL wrap4_gaps got=%0d,%0d,%0d exp=1,3,1", g[0], g[1], g[2]);
      end

      for (int i = 0; i < 8; i++) exp_q.push_back(32'(8 + ((5 + i) % 8)));
      burst(0, 13, 2'b10, 8, 99, 0);
      n_cmp++;
      if (rd_q.size() !== 8) begin
         n_bad++; $display("FAIL wrap8_beats got=%0d exp=8", rd_q.size());
      end
      foreach (rd_q[i]) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_q[i] !== e) begin
            n_bad++; $display("FAIL wrap8_data[%0d] got=%h exp=%h", i, rd_q[i], e);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] rd; int lat; bit ak, er, ex;
      logic [31:0] bd [3];
      int n;
      bit got;
      bd[0] = 32'hA0A0A0A0; bd[1] = 32'hA1A1A1A1; bd[2] = 32'hA2A2A2A2;
      for (int i = 40; i < 43; i++)
         classic(0, 1, wa(i), 4'hF, 32'h55555555, rd, lat, ak, er, ex);
      @(posedge clk); #1;
      tgt = 0; cyc = 1; stb = 1; we_r = 1; addr = wa(40);
      sel = 4'hF; cti = 3'b010; bte_r = 2'b00; wdata = bd[0];
      for (int b = 0; b < 2; b++) begin
         n = 0; got = 0;
         while (n < 20 && !got) begin
            @(negedge clk); n++;
            got = ack_w;
         end
         n_cmp++;
         if (!got) begin
            n_bad++; $display("FAIL rstb_beat%0d_ack got=0 exp=1", b);
         end
         @(posedge clk); #1;
         wdata = bd[b+1];
      end
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (ack_w !== 1'b0) begin
         n_bad++; $display("FAIL rstb_ack_drop got=%b exp=0", ack_w);
      end
      cyc = 0; stb = 0;
      @(posedge clk); #1;
      rst = 0;
      exp_q.push_back(bd[0]);
      exp_q.push_back(bd[1]);
      exp_q.push_back(32'h55555555);
      for (int i = 40; i < 43; i++) begin
         classic(0, 0, wa(i), 4'hF, 32'h0, rd, lat, ak, er, ex);
         n_cmp++;
         if (!ak || rd !== exp_q[0]) begin
            n_bad++; $display("FAIL rstb_word%0d ack=%b got=%h exp=%h", i, ak, rd, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

   initial begin
      test_reset();
      test_classic();
      test_byte_lanes();
      test_wait_states();
      test_decode_error();
      test_burst();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
